usb_spi_arbiter: RTL and testbench

- Sequences all SPI register traffic to the MAX3421E USB host controller on the spi0 pins, and drives its reset line.
- Two requesters share the single SPI link under round-robin arbitration:
  - port 0: the CPU-side bridge;
  - port 1: the hardware keycode/IRQ poll engine.
- Every transaction is one register access: a command byte followed by a data byte.
- The block also synchronizes the chip interrupt line for the poll engine.

---
 rtl/usb_spi_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_usb_spi_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_spi_arbiter.sv
// Round-robin SPI sequencer for the MAX3421E: two requesters, one register access each.
// Optional first-MISO-byte status capture is enabled by defining USB_SPI_STATUS_EN.
module usb_spi_arbiter #(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 1024
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       req0,
  input  logic       we0,
  input  logic [4:0] addr0,
  input  logic [7:0] wdata0,
  output logic       done0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [4:0] addr1,
  input  logic [7:0] wdata1,
  output logic       done1,
  output logic [7:0] rdata1,
  output logic       busy,
  output logic [7:0] status,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss_n,
  input  logic       usb_irq_n,
  output logic       irq_pending,
  output logic       usb_rst_n
);

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, SHIFT, TAIL, GUARD
  } state_t;

  localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
  localparam logic [15:0] RST_END = 16'(RST_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [14:0] tx;
  logic [7:0]  rx;
  logic [3:0]  bitn;
  logic        hi;
  logic        cur;
  logic        last;
  logic        irq_s;
  logic        g0;
  logic        g1;

`ifdef USB_SPI_STATUS_EN
  logic [7:0]  first;
`else
  assign status = 8'h00;
`endif

  // last = 1 means port 1 was served most recently
  assign g0 = req0 && (!req1 || last);
  assign g1 = req1 && !g0;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      bitn      <= '0;
      hi        <= 1'b0;
      cur       <= 1'b0;
      last      <= 1'b1;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_ss_n  <= 1'b1;
      usb_rst_n <= 1'b0;
`ifdef USB_SPI_STATUS_EN
      first     <= '0;
      status    <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        RST_HOLD: begin
          if (cnt == RST_END) begin
            cnt       <= '0;
            usb_rst_n <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        IDLE: begin
          if (g0 || g1) begin
            cur <= g1;
            if (g1) begin
              tx       <= {addr1[3:0], 1'b0, we1, 1'b0,
                           we1 ? wdata1 : 8'h00};
              spi_mosi <= addr1[4];
            end else begin
              tx       <= {addr0[3:0], 1'b0, we0, 1'b0,
                           we0 ? wdata0 : 8'h00};
              spi_mosi <= addr0[4];
            end
            spi_ss_n <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
            bitn     <= '0;
            hi       <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt <= '0;
            if (!hi) begin
              hi       <= 1'b1;
              spi_sclk <= 1'b1;
              rx       <= {rx[6:0], spi_miso};
`ifdef USB_SPI_STATUS_EN
              first    <= {first[6:0], rx[7]};
`endif
            end else begin
              hi       <= 1'b0;
              spi_sclk <= 1'b0;
              tx       <= {tx[13:0], 1'b0};
              if (bitn == 4'd15) begin
                spi_mosi <= 1'b0;
                state    <= TAIL;
              end else begin
                bitn     <= bitn + 4'd1;
                spi_mosi <= tx[14];
              end
            end
          end
        end
        TAIL: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt      <= '0;
            spi_ss_n <= 1'b1;
            busy     <= 1'b0;
            done0    <= !cur;
            done1    <= cur;
            last     <= cur;
            if (cur) rdata1 <= rx;
            else     rdata0 <= rx;
`ifdef USB_SPI_STATUS_EN
            status   <= first;
`endif
            state    <= GUARD;
          end
        end
        GUARD: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + 16'd1;
          end else begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= RST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_s       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_s       <= ~usb_irq_n;
      irq_pending <= irq_s;
    end
  end

endmodule

// File: tb/tb_usb_spi_arbiter.sv
// Directed bench for usb_spi_arbiter: reset hold, write/read framing,
// round-robin order, mid-transfer reset and IRQ synchronizer.
module tb_usb_spi_arbiter;

  logic       clk = 1'b0;
  logic       reset_reset_n;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       done0, done1, busy;
  logic [7:0] rdata0, rdata1, status;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso = 1'b0;
  logic       usb_irq_n, irq_pending, usb_rst_n;

  always #5 clk = ~clk;

  usb_spi_arbiter #(.CLK_DIV(2), .RST_CYCLES(16)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1),
    .busy(busy), .status(status),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_ss_n(spi_ss_n), .usb_irq_n(usb_irq_n),
    .irq_pending(irq_pending), .usb_rst_n(usb_rst_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MISO slave model and MOSI capture
  logic [15:0] miso_word = '0;
  logic [15:0] msh = '0;
  logic [15:0] mosi_cap = '0;
  int          n_rise = 0;
  always @(negedge spi_ss_n or posedge spi_sclk) begin
    if (!spi_sclk) begin
      n_rise   = 0;
      msh      = miso_word;
      spi_miso = miso_word[15];
    end else begin
      mosi_cap = {mosi_cap[14:0], spi_mosi};
      n_rise   = n_rise + 1;
      msh      = {msh[14:0], 1'b0};
      spi_miso = msh[15];
    end
  end

  // Event timestamps and grant log
  logic prev_ss = 1'b1;
  logic prev_urst = 1'b0;
  int   ss_fall_cyc = 0, ss_low = 0, urst_rise_cyc = 0;
  int   done0_cyc = 0, done1_cyc = 0;
  int   n_done0 = 0, n_done1 = 0, n_grant = 0;
  int   glog [0:15];
  always @(negedge clk) begin
    if (prev_ss && !spi_ss_n) begin
      ss_fall_cyc <= cyc;
      ss_low      <= 1;
    end else if (!spi_ss_n) begin
      ss_low <= ss_low + 1;
    end
    prev_ss <= spi_ss_n;
    if (!prev_urst && usb_rst_n) urst_rise_cyc <= cyc;
    prev_urst <= usb_rst_n;
    if (done0) begin
      n_done0             <= n_done0 + 1;
      done0_cyc           <= cyc;
      glog[n_grant % 16]  <= 0;
      n_grant             <= n_grant + 1;
    end
    if (done1) begin
      n_done1             <= n_done1 + 1;
      done1_cyc           <= cyc;
      glog[n_grant % 16]  <= 1;
      n_grant             <= n_grant + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // which: 0 done0, 1 done1, 2 mid-shift bit 7, 3 any done
  task automatic wait_for(input int which, input int limit,
                          output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((which == 0 && done0) || (which == 1 && done1) ||
          (which == 2 && n_rise >= 7 && !spi_ss_n) ||
          (which == 3 && (done0 || done1))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic ok;
  int   rel, t, base, d0;

  initial begin
    reset_reset_n = 1'b0;
    usb_irq_n = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) step();
    check("rst_outs",
          {spi_ss_n, spi_sclk, spi_mosi, busy,
           done0, done1, usb_rst_n, irq_pending}, 8'b1000_0000);
    check("rst_data", {rdata0, rdata1, status}, 24'h0);

    // port 0 write requested during the chip reset hold
    rel = cyc;
    reset_reset_n = 1'b1;
    miso_word = 16'h1234;
    req0 = 1; we0 = 1; addr0 = 5'd17; wdata0 = 8'hA5;
    wait_for(0, 300, ok);
    check("t1_done_seen", ok, 1);
    req0 = 0;
    check("t1_urst_rise", urst_rise_cyc - rel, 16);
    check("t1_ss_fall", ss_fall_cyc - rel, 17);
    check("t1_latency", done0_cyc - ss_fall_cyc, 66);
    check("t1_ss_low", ss_low, 66);
    check("t1_mosi", mosi_cap, 16'h8AA5);
    check("t1_rises", n_rise, 16);
    check("t1_rdata0", rdata0, 8'h34);
    check("t1_busy", {busy, spi_ss_n}, 2'b01);
`ifdef USB_SPI_STATUS_EN
    check("t1_status", status, 8'h12);
`else
    check("t1_status", status, 8'h00);
`endif
    step();
    check("t1_pulse", {done0, done1}, 2'b00);
    check("t1_counts", {n_done0[7:0], n_done1[7:0]}, 16'h0100);

    // port 1 read, right after the previous done
    t = cyc;
    miso_word = 16'h3C5E;
    req1 = 1; we1 = 0; addr1 = 5'd25; wdata1 = 8'hFF;
    wait_for(1, 300, ok);
    check("t2_done_seen", ok, 1);
    req1 = 0;
    check("t2_guard", ss_fall_cyc - t, 2);
    check("t2_latency", done1_cyc - ss_fall_cyc, 66);
    check("t2_mosi", mosi_cap, 16'hC800);
    check("t2_rdata1", rdata1, 8'h5E);
    check("t2_rdata0_held", rdata0, 8'h34);
    check("t2_done0_cnt", n_done0, 1);
`ifdef USB_SPI_STATUS_EN
    check("t2_status", status, 8'h3C);
`else
    check("t2_status", status, 8'h00);
`endif

    // reset asserted in the middle of a shift
    miso_word = 16'hFFFF;
    req0 = 1; we0 = 0; addr0 = 5'd3;
    wait_for(2, 300, ok);
    check("t3_mid_seen", ok, 1);
    reset_reset_n = 1'b0;
    #1;
    check("t3_async",
          {spi_ss_n, spi_sclk, busy, usb_rst_n}, 4'b1000);
    req0 = 0;
    repeat (3) step();
    check("t3_no_done", n_done0, 1);
    check("t3_rdata_rst", {rdata0, rdata1}, 16'h0);

    // both ports from reset, held over four transactions
    base = n_grant;
    rel = cyc;
    reset_reset_n = 1'b1;
    miso_word = 16'h00AA;
    req0 = 1; we0 = 1; addr0 = 5'd1; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 5'd2; wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      wait_for(3, 300, ok);
      check("t4_done_seen", ok, 1);
    end
    req0 = 0; req1 = 0;
    check("t4_urst_rise", urst_rise_cyc - rel, 16);
    check("t4_order",
          {glog[base % 16][0], glog[(base + 1) % 16][0],
           glog[(base + 2) % 16][0], glog[(base + 3) % 16][0]},
          4'b0101);
    check("t4_mosi", mosi_cap, 16'h1222);
    check("t4_rdata", {rdata0, rdata1}, 16'hAAAA);

    // IRQ synchronizer during an active transfer
    d0 = n_done0;
    miso_word = 16'h0000;
    req1 = 1; we1 = 0; addr1 = 5'd4;
    repeat (5) step();
    check("t5_busy", {busy, spi_ss_n}, 2'b10);
    usb_irq_n = 1'b0;
    step();
    check("t5_irq_lat1", irq_pending, 0);
    step();
    check("t5_irq_lat2", irq_pending, 1);
    usb_irq_n = 1'b1;
    step();
    check("t5_irq_hold", irq_pending, 1);
    step();
    check("t5_irq_clear", irq_pending, 0);
    wait_for(1, 300, ok);
    check("t5_done_seen", ok, 1);
    req1 = 0;
    check("t5_rdata1", rdata1, 8'h00);
    check("t5_no_done0", n_done0 - d0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
